// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller slice.
// Holds the controller state encoding, the default bus addresses of the
// four controller registers and the largest supported source count.
package interrupt_controller_pkg;

    localparam int N_SRC_MAX = 16;

    localparam logic [31:0] DEF_PEND_ADDR = 32'hF000_0100;
    localparam logic [31:0] DEF_MASK_ADDR = 32'hF000_0104;
    localparam logic [31:0] DEF_STAT_ADDR = 32'hF000_0108;
    localparam logic [31:0] DEF_EOI_ADDR  = 32'hF000_010C;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } ctrlState_t;

endpackage

// File: rtl/interrupt_controller_prio_encoder.sv
// Fixed-priority encoder used to pick the source to service.
// Ports:
//   i_req   - N_SRC request vector (pending & mask)
//   o_valid - at least one request bit is set
//   o_index - index of the lowest set bit (index 0 has the highest priority)
module int_prio_encoder
    import interrupt_controller_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] i_req,
    output logic             o_valid,
    output logic [3:0]       o_index
);

    // Scanning from the top down lets the lowest set bit overwrite any
    // higher one, which gives index 0 the highest priority.
    always_comb begin
        o_valid = 1'b0;
        o_index = 4'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_valid = 1'b1;
                o_index = 4'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Memory-mapped interrupt controller with edge-detected sources, a source
// mask, fixed priority and a single non-nesting service level.
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   we, re            - bus write / read strobes
//   memAddr           - bus address
//   dataBusIn         - bus write data
//   dataBusOut        - combinational read data, 0 when not selected
//   irq_src           - level requests from peripherals
//   intr              - interrupt request to the CPU (high only in REQ)
//   intr_ack          - CPU acknowledge pulse
//   intr_vec          - index of the source being serviced
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int               BITS      = 32,
    parameter int               N_SRC     = 4,
    parameter logic [BITS-1:0]  PEND_ADDR = BITS'(DEF_PEND_ADDR),
    parameter logic [BITS-1:0]  MASK_ADDR = BITS'(DEF_MASK_ADDR),
    parameter logic [BITS-1:0]  STAT_ADDR = BITS'(DEF_STAT_ADDR),
    parameter logic [BITS-1:0]  EOI_ADDR  = BITS'(DEF_EOI_ADDR)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic             re,
    input  logic [BITS-1:0]  memAddr,
    input  logic [BITS-1:0]  dataBusIn,
    output logic [BITS-1:0]  dataBusOut,
    input  logic [N_SRC-1:0] irq_src,
    output logic             intr,
    input  logic             intr_ack,
    output logic [3:0]       intr_vec
);

    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] r_mask;
    logic [N_SRC-1:0] r_prev;
    logic [3:0]       r_intrVec;
    ctrlState_t       r_state;
    ctrlState_t       w_nextState;

    logic             w_busWrite;
    logic             w_busRead;
    logic             w_eoiWrite;
    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] w_active;
    logic [N_SRC-1:0] w_w1cClear;
    logic [N_SRC-1:0] w_ackClear;
    logic             w_prioValid;
    logic [3:0]       w_prioIdx;
    logic             w_ackTake;
    logic             w_inService;
    logic             w_unusedData;

    assign w_busWrite = we & ~re;
    assign w_busRead  = re & ~we;
    assign w_eoiWrite = w_busWrite && (memAddr == EOI_ADDR);
    assign w_rise     = irq_src & ~r_prev;
    assign w_active   = r_pending & r_mask;
    assign w_w1cClear = (w_busWrite && (memAddr == PEND_ADDR)) ? dataBusIn[N_SRC-1:0] : '0;
    assign w_ackClear = w_ackTake ? (N_SRC'(1) << w_prioIdx) : '0;
    assign intr_vec   = r_intrVec;

    // Only the low N_SRC data bits carry register content.
    assign w_unusedData = ^dataBusIn[BITS-1:N_SRC];

    int_prio_encoder #(
        .N_SRC(N_SRC)
    ) u_prio (
        .i_req  (w_active),
        .o_valid(w_prioValid),
        .o_index(w_prioIdx)
    );

    // Controller state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and CPU-facing outputs. An acknowledge is honoured only in
    // REQ and only while something enabled is still pending; if the request
    // was withdrawn by a mask write or W1C we fall back to IDLE untouched.
    always_comb begin
        w_nextState = r_state;
        w_ackTake   = 1'b0;
        intr        = 1'b0;
        w_inService = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_prioValid) begin
                    w_nextState = REQ;
                end
            end
            REQ: begin
                intr = 1'b1;
                if (!w_prioValid) begin
                    w_nextState = IDLE;
                end else if (intr_ack) begin
                    w_ackTake   = 1'b1;
                    w_nextState = SERV;
                end
            end
            SERV: begin
                w_inService = 1'b1;
                if (w_eoiWrite) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Pending, mask, edge history and vector. A fresh rising edge wins over
    // any clear landing in the same cycle so no event is ever lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
            r_mask    <= '0;
            r_prev    <= '0;
            r_intrVec <= 4'd0;
        end else begin
            r_prev    <= irq_src;
            r_pending <= (r_pending & ~w_w1cClear & ~w_ackClear) | w_rise;
            if (w_busWrite && (memAddr == MASK_ADDR)) begin
                r_mask <= dataBusIn[N_SRC-1:0];
            end
            if (w_ackTake) begin
                r_intrVec <= w_prioIdx;
            end
        end
    end

    // Combinational read-back; the status word carries in_service in the
    // top bit and the current vector in the low nibble.
    always_comb begin
        dataBusOut = '0;
        if (w_busRead) begin
            if (memAddr == PEND_ADDR) begin
                dataBusOut = BITS'(r_pending);
            end else if (memAddr == MASK_ADDR) begin
                dataBusOut = BITS'(r_mask);
            end else if (memAddr == STAT_ADDR) begin
                dataBusOut             = BITS'(r_intrVec);
                dataBusOut[BITS-1]     = w_inService;
            end
        end
    end

endmodule
